// File: rtl/audio_pkg.sv
// Shared types and constants for the audio buffer arbiter.
package audio_pkg;

  localparam int SAMPLE_W = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: grants the eligible consumer that comes after
// the last-granted index, falling back to the last-granted one itself.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic [1:0] eligible;

  always_comb begin
    eligible    = req & ~mask;
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (eligible[~last]) begin
      grant_valid = 1'b1;
      grant_idx   = ~last;
    end else if (eligible[last]) begin
      grant_valid = 1'b1;
      grant_idx   = last;
    end
  end

endmodule

// File: rtl/audio_buffer_arbiter.sv
// Streams each finished RAM buffer once to every subscribed consumer, one
// consumer at a time in round-robin order, with per-sample ready handshake.
module audio_buffer_arbiter
  import audio_pkg::*;
#(
  parameter int BUFFER_DEPTH = 16,
  parameter int TIMEOUT      = 4096
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            ram_buffer_ready_i,
  output logic                            ram_rd_en_o,
  output logic [$clog2(BUFFER_DEPTH)-1:0] ram_rd_addr_o,
  input  logic [SAMPLE_W-1:0]             ram_rd_data_i,
  input  logic [1:0]                      cons_req_i,
  output logic [1:0]                      cons_buffer_ready_o,
  output logic [SAMPLE_W-1:0]             cons_data_o,
  output logic [1:0]                      cons_valid_o,
  input  logic [1:0]                      cons_ready_i,
  output logic                            overrun_o,
  output logic                            timeout_o,
  output logic [2:0]                      state_o
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(BUFFER_DEPTH - 1);
  localparam logic [WW-1:0] WAIT_LIMIT  = WW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;
  logic [1:0]    served;
  logic          last_grant;
  logic          cur;
  logic          grant_valid;
  logic          grant_idx;
  logic          transfer;
  logic          expire;
  logic          last_sample;

  rr_arbiter2 u_rr (
    .req         (cons_req_i),
    .mask        (served),
    .last        (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign last_sample = (count == LAST_SAMPLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A timeout only fires when ready is still low on the final allowed cycle.
  always_comb begin
    state_next = state;
    transfer   = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE:  if (ram_buffer_ready_i) state_next = ARB;
      ARB:   state_next = grant_valid ? FETCH : IDLE;
      FETCH: state_next = LOAD;
      LOAD:  state_next = HOLD;
      HOLD: begin
        if (cons_ready_i[cur]) begin
          transfer   = 1'b1;
          state_next = last_sample ? DONE : FETCH;
        end else if (wait_cnt == WAIT_LIMIT) begin
          expire     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = ARB;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count               <= '0;
      wait_cnt            <= '0;
      served              <= 2'b00;
      last_grant          <= 1'b1;
      cur                 <= 1'b0;
      cons_data_o         <= '0;
      cons_buffer_ready_o <= 2'b00;
      overrun_o           <= 1'b0;
      timeout_o           <= 1'b0;
    end else begin
      cons_buffer_ready_o <= 2'b00;
      if (ram_buffer_ready_i && (state != IDLE)) begin
        overrun_o <= 1'b1;
      end
      case (state)
        IDLE: if (ram_buffer_ready_i) served <= 2'b00;
        ARB: begin
          if (grant_valid) begin
            cur                 <= grant_idx;
            count               <= '0;
            cons_buffer_ready_o <= onehot2(grant_idx);
          end
        end
        LOAD: begin
          cons_data_o <= ram_rd_data_i;
          wait_cnt    <= '0;
        end
        HOLD: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (transfer && !last_sample) begin
            count <= count + 1'b1;
          end
          if (expire) begin
            timeout_o   <= 1'b1;
            served[cur] <= 1'b1;
          end
        end
        DONE: begin
          served[cur] <= 1'b1;
          last_grant  <= cur;
        end
        default: ;
      endcase
    end
  end

  assign ram_rd_en_o   = (state == FETCH);
  assign ram_rd_addr_o = (state == FETCH) ? count[AW-1:0] : '0;
  assign cons_valid_o  = (state == HOLD) ? onehot2(cur) : 2'b00;
  assign state_o       = state;

endmodule

// File: tb/tb_audio_buffer_arbiter.sv
// Bench for audio_buffer_arbiter: two instances (long and short timeout) share
// stimulus and are compared every cycle against a behavioural model.
module tb_audio_buffer_arbiter;
  import audio_pkg::*;

  localparam int DEPTH = 16;
  localparam int TO_A  = 4096;
  localparam int TO_B  = 8;

  localparam int M_IDLE  = 0;
  localparam int M_ARB   = 1;
  localparam int M_BURST = 2;
  localparam int M_DONE  = 3;

  typedef struct packed {
    int          mode;
    int          g;
    int          sample;
    int          phase;
    int          last;
    logic [1:0]  served;
    logic [23:0] data;
    logic        ovr;
    logic        tmo;
  } model_t;

  typedef struct packed {
    logic        en;
    logic [3:0]  addr;
    logic [1:0]  brdy;
    logic [23:0] data;
    logic [1:0]  valid;
    logic        ovr;
    logic        tmo;
    logic [2:0]  st;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pulse;
  logic [1:0]  req;
  logic [1:0]  rdy;

  logic        en_a, en_b;
  logic [3:0]  addr_a, addr_b;
  logic [23:0] rdata_a, rdata_b, data_a, data_b;
  logic [1:0]  brdy_a, brdy_b, valid_a, valid_b;
  logic        ovr_a, ovr_b, tmo_a, tmo_b;
  logic [2:0]  st_a, st_b;

  logic [23:0] ram_mem [DEPTH];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  model_t ma, mb;

  int          q_addr[$];
  int          q_xcyc[$];
  int          q_order[$];
  logic [23:0] q_data[$];
  int          xcnt[2];

  audio_buffer_arbiter #(.BUFFER_DEPTH(DEPTH), .TIMEOUT(TO_A)) dut_a (
    .clk_i(clk), .rst_i(rst), .ram_buffer_ready_i(pulse),
    .ram_rd_en_o(en_a), .ram_rd_addr_o(addr_a), .ram_rd_data_i(rdata_a),
    .cons_req_i(req), .cons_buffer_ready_o(brdy_a), .cons_data_o(data_a),
    .cons_valid_o(valid_a), .cons_ready_i(rdy), .overrun_o(ovr_a),
    .timeout_o(tmo_a), .state_o(st_a)
  );

  audio_buffer_arbiter #(.BUFFER_DEPTH(DEPTH), .TIMEOUT(TO_B)) dut_b (
    .clk_i(clk), .rst_i(rst), .ram_buffer_ready_i(pulse),
    .ram_rd_en_o(en_b), .ram_rd_addr_o(addr_b), .ram_rd_data_i(rdata_b),
    .cons_req_i(req), .cons_buffer_ready_o(brdy_b), .cons_data_o(data_b),
    .cons_valid_o(valid_b), .cons_ready_i(rdy), .overrun_o(ovr_b),
    .timeout_o(tmo_b), .state_o(st_b)
  );

  // RAM with one-cycle read latency, one read port per instance.
  always @(posedge clk) begin
    if (en_a) rdata_a <= ram_mem[addr_a];
    if (en_b) rdata_b <= ram_mem[addr_b];
  end

  function automatic logic bit_of(input logic [1:0] v, input int i);
    return (i == 1) ? v[1] : v[0];
  endfunction

  function automatic logic [1:0] sel(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.mode = M_IDLE; m.g = 0; m.sample = 0; m.phase = 0; m.last = 1;
    m.served = 2'b00; m.data = 24'h0; m.ovr = 1'b0; m.tmo = 1'b0;
    return m;
  endfunction

  // One clock edge of behaviour: phase counts cycles since the sample's read.
  function automatic model_t model_step(input model_t m, input int tmo_lim, input logic r,
                                        input logic p, input logic [1:0] rq, input logic [1:0] rd);
    model_t n;
    int c;
    n = m;
    if (r) return model_reset();
    if (p && m.mode != M_IDLE) n.ovr = 1'b1;
    case (m.mode)
      M_IDLE: if (p) begin n.served = 2'b00; n.mode = M_ARB; end
      M_ARB: begin
        n.mode = M_IDLE;
        for (int k = 1; k <= 2; k++) begin
          c = (m.last + k) % 2;
          if (bit_of(rq, c) && !bit_of(m.served, c) && n.mode == M_IDLE) begin
            n.mode = M_BURST; n.g = c; n.sample = 0; n.phase = 0;
          end
        end
      end
      M_BURST: begin
        if (m.phase == 0) n.phase = 1;
        else if (m.phase == 1) begin
          n.phase = 2;
          n.data  = ram_mem[4'(m.sample)];
        end else if (bit_of(rd, m.g)) begin
          if (m.sample == DEPTH - 1) n.mode = M_DONE;
          else begin n.sample = m.sample + 1; n.phase = 0; end
        end else if (m.phase - 2 == tmo_lim - 1) begin
          n.tmo = 1'b1; n.served = m.served | sel(m.g); n.mode = M_DONE;
        end else n.phase = m.phase + 1;
      end
      default: begin
        n.served = m.served | sel(m.g); n.last = m.g; n.mode = M_ARB;
      end
    endcase
    return n;
  endfunction

  function automatic exp_t model_out(input model_t m);
    exp_t e;
    e = '0;
    e.data = m.data; e.ovr = m.ovr; e.tmo = m.tmo;
    case (m.mode)
      M_IDLE: e.st = IDLE;
      M_ARB:  e.st = ARB;
      M_DONE: e.st = DONE;
      default: begin
        if (m.phase == 0) begin
          e.st = FETCH; e.en = 1'b1; e.addr = 4'(m.sample);
          if (m.sample == 0) e.brdy = sel(m.g);
        end else if (m.phase == 1) e.st = LOAD;
        else begin e.st = HOLD; e.valid = sel(m.g); end
      end
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, want, cyc);
    end
  endtask

  task automatic compare_all();
    exp_t ea, eb;
    ea = model_out(ma);
    eb = model_out(mb);
    checkOutput("A.ram_rd_en_o", 32'(en_a), 32'(ea.en));
    checkOutput("A.ram_rd_addr_o", 32'(addr_a), 32'(ea.addr));
    checkOutput("A.cons_buffer_ready_o", 32'(brdy_a), 32'(ea.brdy));
    checkOutput("A.cons_data_o", 32'(data_a), 32'(ea.data));
    checkOutput("A.cons_valid_o", 32'(valid_a), 32'(ea.valid));
    checkOutput("A.overrun_o", 32'(ovr_a), 32'(ea.ovr));
    checkOutput("A.timeout_o", 32'(tmo_a), 32'(ea.tmo));
    checkOutput("A.state_o", 32'(st_a), 32'(ea.st));
    checkOutput("B.ram_rd_en_o", 32'(en_b), 32'(eb.en));
    checkOutput("B.ram_rd_addr_o", 32'(addr_b), 32'(eb.addr));
    checkOutput("B.cons_buffer_ready_o", 32'(brdy_b), 32'(eb.brdy));
    checkOutput("B.cons_data_o", 32'(data_b), 32'(eb.data));
    checkOutput("B.cons_valid_o", 32'(valid_b), 32'(eb.valid));
    checkOutput("B.overrun_o", 32'(ovr_b), 32'(eb.ovr));
    checkOutput("B.timeout_o", 32'(tmo_b), 32'(eb.tmo));
    checkOutput("B.state_o", 32'(st_b), 32'(eb.st));
  endtask

  // Inputs change and outputs are compared on the falling edge.
  task automatic applyStimulus(input logic p, input logic [1:0] r, input logic [1:0] y);
    pulse = p; req = r; rdy = y;
    @(posedge clk);
    ma = model_step(ma, TO_A, rst, pulse, req, rdy);
    mb = model_step(mb, TO_B, rst, pulse, req, rdy);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic observe(input logic [1:0] y);
    if (en_a) q_addr.push_back(int'(addr_a));
    if (brdy_a[0]) q_order.push_back(0);
    if (brdy_a[1]) q_order.push_back(1);
    for (int i = 0; i < 2; i++) begin
      if (bit_of(valid_a, i) && bit_of(y, i)) begin
        xcnt[i]++;
        q_xcyc.push_back(cyc);
        q_data.push_back(data_a);
      end
    end
  endtask

  task automatic clear_obs();
    q_addr.delete(); q_xcyc.delete(); q_order.delete(); q_data.delete();
    xcnt[0] = 0; xcnt[1] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = 24'($urandom);
  endtask

  task automatic run_until_idle(input logic [1:0] r, input logic [1:0] y, input int budget);
    int n;
    n = 0;
    do begin
      observe(y);
      applyStimulus(1'b0, r, y);
      n++;
    end while ((st_a != IDLE || st_b != IDLE) && n < budget);
    checkOutput("settle.A_idle", 32'(st_a), 32'(IDLE));
    checkOutput("settle.B_idle", 32'(st_b), 32'(IDLE));
  endtask

  initial begin
    int n;
    int hold0;
    int xb1;
    logic stalled;
    logic [23:0] held;

    rst = 1'b1; pulse = 1'b0; req = 2'b00; rdy = 2'b00;
    ma = model_reset(); mb = model_reset();
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = 24'($urandom);

    $display("[TB] reset state");
    do_reset();
    checkOutput("reset.state", 32'(st_a), 32'(IDLE));
    checkOutput("reset.valid", 32'(valid_a), 32'd0);
    checkOutput("reset.data", 32'(data_a), 32'd0);

    $display("[TB] single consumer");
    clear_obs();
    applyStimulus(1'b1, 2'b01, 2'b11);
    run_until_idle(2'b01, 2'b11, 200);
    checkOutput("single.reads", 32'(q_addr.size()), 32'd16);
    checkOutput("single.xfers0", 32'(xcnt[0]), 32'd16);
    checkOutput("single.xfers1", 32'(xcnt[1]), 32'd0);
    for (int i = 0; i < q_addr.size(); i++) checkOutput("single.addr", 32'(q_addr[i]), 32'(i));
    for (int i = 0; i < q_data.size(); i++) checkOutput("single.data", 32'(q_data[i]), 32'(ram_mem[i]));
    for (int i = 1; i < q_xcyc.size(); i++) checkOutput("single.spacing", 32'(q_xcyc[i] - q_xcyc[i-1]), 32'd3);

    $display("[TB] both consumers");
    do_reset();
    clear_obs();
    applyStimulus(1'b1, 2'b11, 2'b11);
    run_until_idle(2'b11, 2'b11, 400);
    checkOutput("both.bursts", 32'(q_order.size()), 32'd2);
    checkOutput("both.first", 32'(q_order[0]), 32'd0);
    checkOutput("both.second", 32'(q_order[1]), 32'd1);
    checkOutput("both.xfers0", 32'(xcnt[0]), 32'd16);
    checkOutput("both.xfers1", 32'(xcnt[1]), 32'd16);
    clear_obs();
    applyStimulus(1'b1, 2'b01, 2'b11);
    run_until_idle(2'b01, 2'b11, 200);
    clear_obs();
    applyStimulus(1'b1, 2'b11, 2'b11);
    run_until_idle(2'b11, 2'b11, 400);
    checkOutput("rotate.first", 32'(q_order[0]), 32'd1);
    checkOutput("rotate.second", 32'(q_order[1]), 32'd0);

    $display("[TB] backpressure");
    do_reset();
    clear_obs();
    stalled = 1'b0;
    held = 24'h0;
    n = 0;
    applyStimulus(1'b1, 2'b01, 2'b11);
    while ((st_a != IDLE || st_b != IDLE) && n < 400) begin
      if (!stalled && valid_a[0] && xcnt[0] == 5) begin
        stalled = 1'b1;
        held = data_a;
        checkOutput("bp.held_is_sample5", 32'(held), 32'(ram_mem[5]));
        for (int k = 0; k < 10; k++) begin
          applyStimulus(1'b0, 2'b01, 2'b00);
          checkOutput("bp.data_held", 32'(data_a), 32'(held));
          checkOutput("bp.valid_held", 32'(valid_a), 32'd1);
          checkOutput("bp.no_rd_en", 32'(en_a), 32'd0);
        end
      end
      observe(2'b11);
      applyStimulus(1'b0, 2'b01, 2'b11);
      n++;
    end
    checkOutput("bp.stall_seen", 32'(stalled), 32'd1);
    checkOutput("bp.xfers", 32'(xcnt[0]), 32'd16);

    $display("[TB] overrun");
    do_reset();
    clear_obs();
    applyStimulus(1'b1, 2'b01, 2'b11);
    for (int k = 0; k < 10; k++) begin observe(2'b11); applyStimulus(1'b0, 2'b01, 2'b11); end
    observe(2'b11);
    applyStimulus(1'b1, 2'b01, 2'b11);
    run_until_idle(2'b01, 2'b11, 200);
    for (int k = 0; k < 10; k++) begin observe(2'b11); applyStimulus(1'b0, 2'b01, 2'b11); end
    checkOutput("ovr.flag", 32'(ovr_a), 32'd1);
    checkOutput("ovr.bursts", 32'(q_order.size()), 32'd1);
    checkOutput("ovr.xfers", 32'(xcnt[0]), 32'd16);

    $display("[TB] timeout");
    do_reset();
    hold0 = 0; xb1 = 0; n = 0;
    applyStimulus(1'b1, 2'b11, 2'b10);
    while (st_b != IDLE && n < 300) begin
      if (valid_b[0]) hold0++;
      if (valid_b[1]) xb1++;
      applyStimulus(1'b0, 2'b11, 2'b10);
      n++;
    end
    checkOutput("tmo.hold_cycles", 32'(hold0), 32'd8);
    checkOutput("tmo.flag_b", 32'(tmo_b), 32'd1);
    checkOutput("tmo.other_served", 32'(xb1), 32'd16);
    checkOutput("tmo.flag_a", 32'(tmo_a), 32'd0);
    checkOutput("tmo.a_still_holding", 32'(valid_a), 32'd1);
    run_until_idle(2'b11, 2'b11, 400);

    $display("[TB] reset mid-burst");
    do_reset();
    clear_obs();
    n = 0;
    applyStimulus(1'b1, 2'b01, 2'b11);
    while (!(valid_a[0] && xcnt[0] == 7) && n < 200) begin
      observe(2'b11);
      applyStimulus(1'b0, 2'b01, 2'b11);
      n++;
    end
    checkOutput("rstmid.at_sample7", 32'(xcnt[0]), 32'd7);
    rst = 1'b1;
    applyStimulus(1'b0, 2'b01, 2'b11);
    rst = 1'b0;
    checkOutput("rstmid.state", 32'(st_a), 32'(IDLE));
    checkOutput("rstmid.valid", 32'(valid_a), 32'd0);
    checkOutput("rstmid.data", 32'(data_a), 32'd0);
    checkOutput("rstmid.rd_en", 32'(en_a), 32'd0);
    clear_obs();
    for (int k = 0; k < 20; k++) begin observe(2'b11); applyStimulus(1'b0, 2'b01, 2'b11); end
    checkOutput("rstmid.quiet_reads", 32'(q_addr.size()), 32'd0);
    checkOutput("rstmid.quiet_xfers", 32'(xcnt[0]), 32'd0);
    applyStimulus(1'b1, 2'b01, 2'b11);
    run_until_idle(2'b01, 2'b11, 200);
    checkOutput("rstmid.resume", 32'(xcnt[0]), 32'd16);

    $display("[TB] random traffic");
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      applyStimulus($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)),
                    {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
    end
    rst = 1'b0;
    run_until_idle(2'b11, 2'b11, 9000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
